// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory front-end and memory_subsystem.
package mem_pkg;

    localparam int unsigned ADDR_WIDTH = 14;
    localparam int unsigned DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } coherency_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]                           req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]   rr_ptr,
    output logic [N-1:0]                           win_onehot_c,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]   win_idx_c,
    output logic                                   any_req_c
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic          found;
    logic [PW-1:0] cand;

    // Walk the request vector starting at rr_ptr; first hit wins.
    always_comb begin
        win_onehot_c = '0;
        win_idx_c    = '0;
        found        = 1'b0;
        cand         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = PW'((32'(rr_ptr) + k) % N);
            if (!found && req[cand]) begin
                found              = 1'b1;
                win_idx_c          = cand;
                win_onehot_c[cand] = 1'b1;
            end
        end
    end

    assign any_req_c = |req;

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that serialises processor read/write requests onto one memory port.
module mem_req_arbiter #(
    parameter int unsigned NUM_PROCESSORS = 4,
    parameter int unsigned ADDR_WIDTH     = mem_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = mem_pkg::DATA_WIDTH,
    parameter int unsigned TIMEOUT        = 32
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_PROCESSORS-1:0]            proc_req,
    input  logic [NUM_PROCESSORS-1:0]            proc_we,
    input  logic [NUM_PROCESSORS*ADDR_WIDTH-1:0] proc_addr,
    input  logic [NUM_PROCESSORS*DATA_WIDTH-1:0] proc_wdata,
    output logic [NUM_PROCESSORS-1:0]            proc_grant,
    output logic [NUM_PROCESSORS-1:0]            proc_done,
    output logic                                 proc_err,
    output logic [DATA_WIDTH-1:0]                proc_rdata,
    output logic                                 mem_read_req,
    output logic                                 mem_write_req,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_write_data,
    output logic [NUM_PROCESSORS-1:0]            mem_proc_sel,
    input  logic [NUM_PROCESSORS-1:0]            mem_proc_resp,
    input  logic [DATA_WIDTH-1:0]                mem_read_data
);

    import mem_pkg::*;

    localparam int unsigned PTR_W = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t                state, state_nxt;
    logic [PTR_W-1:0]          rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]          tmo_cnt, tmo_cnt_nxt;

    logic [NUM_PROCESSORS-1:0] grant_nxt, done_nxt, sel_nxt;
    logic                      err_nxt, rd_nxt, wr_nxt;
    logic [DATA_WIDTH-1:0]     rdata_nxt, wdata_nxt;
    logic [ADDR_WIDTH-1:0]     addr_nxt;

    logic [NUM_PROCESSORS-1:0] win_onehot_c;
    logic [PTR_W-1:0]          win_idx_c;
    logic                      any_req_c;

    logic [ADDR_WIDTH-1:0]     addr_arr  [NUM_PROCESSORS];
    logic [DATA_WIDTH-1:0]     wdata_arr [NUM_PROCESSORS];

    // Unpack per-processor address and write-data slices.
    for (genvar g = 0; g < NUM_PROCESSORS; g++) begin : g_unpack
        assign addr_arr[g]  = proc_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = proc_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .N (NUM_PROCESSORS)
    ) u_pick (
        .req          (proc_req),
        .rr_ptr       (rr_ptr),
        .win_onehot_c (win_onehot_c),
        .win_idx_c    (win_idx_c),
        .any_req_c    (any_req_c)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            tmo_cnt        <= '0;
            proc_grant     <= '0;
            proc_done      <= '0;
            proc_err       <= 1'b0;
            proc_rdata     <= '0;
            mem_read_req   <= 1'b0;
            mem_write_req  <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_proc_sel   <= '0;
        end else begin
            state          <= state_nxt;
            rr_ptr         <= rr_ptr_nxt;
            tmo_cnt        <= tmo_cnt_nxt;
            proc_grant     <= grant_nxt;
            proc_done      <= done_nxt;
            proc_err       <= err_nxt;
            proc_rdata     <= rdata_nxt;
            mem_read_req   <= rd_nxt;
            mem_write_req  <= wr_nxt;
            mem_addr       <= addr_nxt;
            mem_write_data <= wdata_nxt;
            mem_proc_sel   <= sel_nxt;
        end
    end

    // Next-state and next-output logic; memory side only changes on grant or completion.
    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        tmo_cnt_nxt = tmo_cnt;
        grant_nxt   = proc_grant;
        done_nxt    = '0;
        err_nxt     = 1'b0;
        rdata_nxt   = proc_rdata;
        rd_nxt      = mem_read_req;
        wr_nxt      = mem_write_req;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_write_data;
        sel_nxt     = mem_proc_sel;

        unique case (state)
            IDLE: begin
                if (any_req_c) begin
                    state_nxt   = BUSY;
                    grant_nxt   = win_onehot_c;
                    sel_nxt     = win_onehot_c;
                    addr_nxt    = addr_arr[win_idx_c];
                    wdata_nxt   = wdata_arr[win_idx_c];
                    wr_nxt      = proc_we[win_idx_c];
                    rd_nxt      = !proc_we[win_idx_c];
                    tmo_cnt_nxt = '0;
                    rr_ptr_nxt  = (win_idx_c == PTR_W'(NUM_PROCESSORS - 1)) ?
                                  '0 : win_idx_c + PTR_W'(1);
                end
            end
            BUSY: begin
                tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                if (|(mem_proc_resp & mem_proc_sel)) begin
                    state_nxt   = DONE;
                    done_nxt    = proc_grant;
                    rdata_nxt   = mem_read_req ? mem_read_data : proc_rdata;
                    rd_nxt      = 1'b0;
                    wr_nxt      = 1'b0;
                    sel_nxt     = '0;
                    tmo_cnt_nxt = '0;
                end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt   = DONE;
                    done_nxt    = proc_grant;
                    err_nxt     = 1'b1;
                    rdata_nxt   = '0;
                    rd_nxt      = 1'b0;
                    wr_nxt      = 1'b0;
                    sel_nxt     = '0;
                    tmo_cnt_nxt = '0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_req_arbiter;

    localparam int N   = 4;
    localparam int AW  = 14;
    localparam int DW  = 16;
    localparam int TMO = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [N-1:0]      proc_req, proc_we;
    logic [N*AW-1:0]   proc_addr;
    logic [N*DW-1:0]   proc_wdata;
    logic [N-1:0]      proc_grant, proc_done;
    logic              proc_err;
    logic [DW-1:0]     proc_rdata;
    logic              mem_read_req, mem_write_req;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_write_data;
    logic [N-1:0]      mem_proc_sel;
    logic [N-1:0]      mem_proc_resp;
    logic [DW-1:0]     mem_read_data;

    mem_req_arbiter #(
        .NUM_PROCESSORS (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT        (TMO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .proc_req       (proc_req),
        .proc_we        (proc_we),
        .proc_addr      (proc_addr),
        .proc_wdata     (proc_wdata),
        .proc_grant     (proc_grant),
        .proc_done      (proc_done),
        .proc_err       (proc_err),
        .proc_rdata     (proc_rdata),
        .mem_read_req   (mem_read_req),
        .mem_write_req  (mem_write_req),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_proc_sel   (mem_proc_sel),
        .mem_proc_resp  (mem_proc_resp),
        .mem_read_data  (mem_read_data)
    );

    int total = 0;
    int bad   = 0;

    // Processor-side view held by the bench and the reference model state.
    logic [N-1:0]  req_m;
    logic          we_v    [N];
    logic [AW-1:0] addr_v  [N];
    logic [DW-1:0] wdata_v [N];
    int            rr_m;
    logic [DW-1:0] rdata_m;
    bit            force_write;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        proc_req = req_m;
        for (int i = 0; i < N; i++) begin
            proc_we[i]               = we_v[i];
            proc_addr[i*AW +: AW]    = addr_v[i];
            proc_wdata[i*DW +: DW]   = wdata_v[i];
        end
    endtask

    task automatic set_proc(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we_v[i]    = we;
        addr_v[i]  = a;
        wdata_v[i] = d;
    endtask

    task automatic rand_proc(input int i);
        set_proc(i, force_write ? 1'b1 : 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, proc_grant, 0);
        chk({tag, "_done"},  proc_done, 0);
        chk({tag, "_err"},   proc_err, 0);
        chk({tag, "_rdata"}, proc_rdata, 0);
        chk({tag, "_rd"},    mem_read_req, 0);
        chk({tag, "_wr"},    mem_write_req, 0);
        chk({tag, "_addr"},  mem_addr, 0);
        chk({tag, "_wdata"}, mem_write_data, 0);
        chk({tag, "_sel"},   mem_proc_sel, 0);
    endtask

    // Model: first requester at or after the rotating pointer, modulo N.
    function automatic int pick_winner();
        for (int k = 0; k < N; k++) begin
            if (req_m[(rr_m + k) % N]) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    // One full transaction from an IDLE decision point back to the following IDLE cycle.
    task automatic run_txn(input int lat, input bit tmo, input bit glitch,
                           input logic [N-1:0] noise, input logic [DW-1:0] rd_val,
                           input logic [N-1:0] rereq);
        int            w;
        int            n_wait;
        logic [N-1:0]  oh;
        logic [N-1:0]  newreq;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ewe;
        w = pick_winner();
        if (w < 0) begin
            chk("no_requester", 0, 1);
            return;
        end
        oh  = N'(1) << w;
        ea  = addr_v[w];
        ed  = wdata_v[w];
        ewe = we_v[w];
        drive();
        step();
        rr_m = (w + 1) % N;
        chk("grant",     proc_grant, oh);
        chk("sel",       mem_proc_sel, oh);
        chk("wr_strobe", mem_write_req, ewe);
        chk("rd_strobe", mem_read_req, !ewe);
        chk("mem_addr",  mem_addr, ea);
        chk("mem_wdata", mem_write_data, ed);
        chk("busy_done", proc_done, 0);

        n_wait = tmo ? TMO - 1 : lat;
        for (int c = 0; c < n_wait; c++) begin
            mem_proc_resp = noise & ~oh;
            mem_read_data = DW'($urandom);
            if (glitch && c == 0) begin
                addr_v[w] = ~ea;
                drive();
            end
            step();
            chk("hold_done",  proc_done, 0);
            chk("hold_addr",  mem_addr, ea);
            chk("hold_grant", proc_grant, oh);
            chk("hold_wr",    mem_write_req, ewe);
        end

        mem_proc_resp = tmo ? (noise & ~oh) : (noise | oh);
        mem_read_data = rd_val;
        step();
        if (tmo)       rdata_m = '0;
        else if (!ewe) rdata_m = rd_val;
        chk("done",       proc_done, oh);
        chk("done_err",   proc_err, tmo);
        chk("done_rdata", proc_rdata, rdata_m);
        chk("done_grant", proc_grant, oh);
        chk("done_rd",    mem_read_req, 0);
        chk("done_wr",    mem_write_req, 0);
        chk("done_sel",   mem_proc_sel, 0);

        // Winner sees its done pulse and drops; others may raise new requests now.
        mem_proc_resp = '0;
        req_m[w]      = 1'b0;
        newreq        = rereq & ~req_m;
        for (int i = 0; i < N; i++) if (newreq[i]) rand_proc(i);
        req_m = req_m | newreq;
        drive();
        step();
        chk("idle_grant", proc_grant, 0);
        chk("idle_done",  proc_done, 0);
        chk("idle_err",   proc_err, 0);
        chk("idle_rd",    mem_read_req, 0);
        chk("idle_wr",    mem_write_req, 0);
        chk("idle_rdata", proc_rdata, rdata_m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        mem_proc_resp = '0;
        mem_read_data = '0;
        force_write   = 1'b1;
        rr_m          = 0;
        rdata_m       = '0;
        req_m         = 4'b1111;
        for (int i = 0; i < N; i++) rand_proc(i);
        drive();

        // Reset held with every processor requesting.
        for (int c = 0; c < 3; c++) begin
            step();
            chk_all_zero("reset");
        end
        reset_n = 1'b1;

        // All four writing continuously: rotation 0,1,2,3,0 with the winner re-requesting.
        for (int t = 0; t < 5; t++) begin
            chk("rotate_order", 64'(pick_winner()), 64'(t % N));
            run_txn(3, 1'b0, 1'b0, '0, DW'($urandom), 4'b1111);
        end
        force_write = 1'b0;
        req_m = '0;
        drive();
        step();
        chk("quiet_grant", proc_grant, 0);

        // P2 read of 0x0123 answered with 0xBEEF.
        req_m = 4'b0100;
        set_proc(2, 1'b0, 14'h0123, 16'h0000);
        run_txn(10, 1'b0, 1'b0, '0, 16'hBEEF, '0);
        chk("beef_rdata", proc_rdata, 16'hBEEF);

        // P1 changes its address mid-transaction while P0's response bit fires.
        req_m = 4'b0010;
        set_proc(1, 1'b1, 14'h2A5A, 16'h1234);
        run_txn(5, 1'b0, 1'b1, 4'b0001, 16'hDEAD, '0);

        // P3 read with no memory response: timeout completion.
        req_m = 4'b1000;
        set_proc(3, 1'b0, 14'h3FFF, 16'h0000);
        run_txn(0, 1'b1, 1'b0, '0, 16'hCAFE, '0);
        chk("tmo_rdata", proc_rdata, 0);

        // Reset pulsed during BUSY aborts silently and clears the pointer.
        req_m = 4'b0100;
        set_proc(2, 1'b0, 14'h0042, 16'h0000);
        drive();
        step();
        chk("abort_grant", proc_grant, 4'b0100);
        step();
        step();
        reset_n = 1'b0;
        step();
        chk_all_zero("abort");
        reset_n = 1'b1;
        rr_m    = 0;
        rdata_m = '0;
        req_m   = 4'b1010;
        set_proc(1, 1'b0, 14'h0111, 16'h0000);
        set_proc(3, 1'b0, 14'h0333, 16'h0000);
        drive();
        chk("after_reset_pick", 64'(pick_winner()), 1);
        run_txn(2, 1'b0, 1'b0, '0, 16'h5A5A, '0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            if (req_m == '0) begin
                int idle_n;
                idle_n = $urandom_range(0, 3);
                for (int c = 0; c < idle_n; c++) begin
                    step();
                    chk("rand_idle_grant", proc_grant, 0);
                end
                req_m = N'($urandom_range(1, (1 << N) - 1));
                for (int i = 0; i < N; i++) if (req_m[i]) rand_proc(i);
            end
            run_txn($urandom_range(0, 6), $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
                    N'($urandom), DW'($urandom), N'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
